// File: rtl/mul6_rr_sched_if.sv
// Bundle of request/response handshake and multiplier-side signals for the
// shared multiplier scheduler. The slave modport is the scheduler's view; the
// master modport is the environment (requesters plus the multiplier datapath).
interface mul6_rr_sched_if #(
    parameter int NREQ = 4
);
    // Requester side
    logic [NREQ-1:0]   req_valid;
    logic [6*NREQ-1:0] req_a;
    logic [6*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;

    // Response side
    logic [NREQ-1:0]   rsp_valid;
    logic              rsp_ready;
    logic [11:0]       rsp_c;
    logic              rsp_neg;

    // Multiplier side
    logic [5:0]        mul_a;
    logic [5:0]        mul_b;
    logic              mul_rst;
    logic              mul_start;
    logic [11:0]       mul_c;
    logic              mul_neg;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_c, mul_neg,
        output req_ready, rsp_valid, rsp_c, rsp_neg,
        output mul_a, mul_b, mul_rst, mul_start
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_c, mul_neg,
        input  req_ready, rsp_valid, rsp_c, rsp_neg,
        input  mul_a, mul_b, mul_rst, mul_start
    );
endinterface

// File: rtl/mul6_rr_sched.sv
// Round-robin scheduler sharing one 6x6 signed multiplier between NREQ
// requesters. One operation is in flight at a time: the granted operand pair is
// latched, the multiplier is cleared, started for MUL_LAT cycles, and its
// product/sign are captured and returned with a one-hot valid/ready response.
module mul6_rr_sched #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 6
) (
    input  logic            clk,
    input  logic            rst,
    mul6_rr_sched_if.slave  bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SETUP = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    logic [IW-1:0]     r_last;
    logic [IW-1:0]     r_grant;
    logic [CW-1:0]     r_cnt;
    logic [5:0]        r_mul_a;
    logic [5:0]        r_mul_b;
    logic              r_mul_rst;
    logic              r_mul_start;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [11:0]       r_rsp_c;
    logic              r_rsp_neg;

    logic              w_found;
    logic [IW-1:0]     w_pick;
    logic [IW-1:0]     w_idx;
    logic [NREQ-1:0]   w_req_ready;
    logic [5:0]        w_op_a;
    logic [5:0]        w_op_b;

    // One-hot vector for a requester index
    function automatic logic [NREQ-1:0] f_onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (idx == IW'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Round-robin search starting just after the last served requester
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IW'((int'(r_last) + k) % NREQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Operand mux for the candidate requester
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == IW'(i)) begin
                w_op_a = bus.req_a[6*i +: 6];
                w_op_b = bus.req_b[6*i +: 6];
            end
        end
    end

    // Accept pulse is only offered while idle, in the same cycle as the grant
    always_comb begin
        w_req_ready = '0;
        if (r_state == S_IDLE && w_found) begin
            w_req_ready = f_onehot(w_pick);
        end
    end

    // Sequencer: arbitrate, drive the multiplier rst/start protocol, return result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_last      <= IW'(NREQ - 1);
            r_grant     <= IW'(NREQ - 1);
            r_cnt       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_rst   <= 1'b1;
            r_mul_start <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_c     <= '0;
            r_rsp_neg   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mul_rst   <= 1'b0;
                    r_mul_start <= 1'b0;
                    if (w_found) begin
                        r_grant   <= w_pick;
                        r_mul_a   <= w_op_a;
                        r_mul_b   <= w_op_b;
                        r_mul_rst <= 1'b1;
                        r_state   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    // Multiplier sees one cycle of reset, then operands settle
                    r_mul_rst <= 1'b0;
                    r_state   <= S_SETUP;
                end
                S_SETUP: begin
                    r_mul_start <= 1'b1;
                    r_cnt       <= CW'(MUL_LAT - 1);
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_mul_start <= 1'b0;
                        r_rsp_c     <= bus.mul_c;
                        r_rsp_neg   <= bus.mul_neg;
                        r_rsp_valid <= f_onehot(r_grant);
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= '0;
                        r_last      <= r_grant;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_c     = r_rsp_c;
    assign bus.rsp_neg   = r_rsp_neg;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.mul_rst   = r_mul_rst;
    assign bus.mul_start = r_mul_start;

endmodule

// File: tb/tb_mul6_rr_sched.sv
// Scoreboard bench for the round-robin multiplier scheduler, with a behavioural
// multiplier that only shows a correct product after MUL_LAT start cycles.
module tb_mul6_rr_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 6;

    typedef struct {
        int          idx;
        logic [11:0] c;
        logic        neg;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul6_rr_sched_if #(.NREQ(NREQ)) bus ();

    mul6_rr_sched #(.NREQ(NREQ), .MUL_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // c = |A|*|B|, neg = sign(A) xor sign(B)
    function automatic logic [12:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
        int ia, ib;
        ia = $signed(a);
        ib = $signed(b);
        if (ia < 0) ia = -ia;
        if (ib < 0) ib = -ib;
        return {a[5] ^ b[5], 12'(ia * ib)};
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (last + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Behavioural multiplier: garbage until enough start cycles have elapsed
    int scnt = 0;
    always @(posedge clk) begin
        if (bus.mul_rst) scnt <= 0;
        else if (bus.mul_start) scnt <= scnt + 1;
    end
    always_comb begin
        if (bus.mul_start && !bus.mul_rst && scnt >= LAT - 1)
            {bus.mul_neg, bus.mul_c} = ref_mul(bus.mul_a, bus.mul_b);
        else
            {bus.mul_neg, bus.mul_c} = 13'h1ABC;
    end

    // Requester state
    logic [5:0]      opa [NREQ];
    logic [5:0]      opb [NREQ];
    logic [NREQ-1:0] want  = '0;
    logic [NREQ-1:0] rearm = '0;
    bit              arm_en  = 0;
    bit              drop_en = 0;
    int              acc_cnt  [NREQ];
    int              seen_cnt [NREQ];

    // Reference model / scoreboard state (owned by the monitor)
    exp_t        q[$];
    int          glog[$];
    int          last_g = NREQ - 1;
    bit          busy   = 0;
    logic [11:0] res_c   [NREQ];
    logic        res_neg [NREQ];
    logic [NREQ-1:0] prev_rv   = '0;
    logic [11:0]     prev_c    = '0;
    logic            prev_neg  = 1'b0;
    bit              prev_wait = 0;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            acc_cnt[i] = 0; seen_cnt[i] = 0; opa[i] = '0; opb[i] = '0;
            res_c[i] = '0; res_neg[i] = 1'b0;
        end
    end

    // Monitor: checks grants against the round-robin model and responses against the queue
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            busy      = 0;
            last_g    = NREQ - 1;
            prev_rv   = '0;
            prev_c    = '0;
            prev_neg  = 1'b0;
            prev_wait = 0;
        end else begin
            if (busy) begin
                chk(bus.req_ready == '0, "grant_while_busy", bus.req_ready, 0);
            end else begin
                int g;
                logic [NREQ-1:0] e1h;
                g = rr_pick(bus.req_valid, last_g);
                e1h = '0;
                if (g >= 0) e1h[g] = 1'b1;
                chk(bus.req_ready == e1h, "grant", bus.req_ready, e1h);
                if (g >= 0 && bus.req_ready != '0) begin
                    exp_t e;
                    logic [12:0] r;
                    r = ref_mul(opa[g], opb[g]);
                    e.idx = g; e.c = r[11:0]; e.neg = r[12]; e.cyc = cyc;
                    q.push_back(e);
                    glog.push_back(g);
                    last_g = g;
                    busy   = 1;
                end
            end
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) acc_cnt[i]++;

            if (prev_wait) begin
                chk(bus.rsp_valid == prev_rv, "hold_valid", bus.rsp_valid, prev_rv);
                chk(bus.rsp_c == prev_c, "hold_c", bus.rsp_c, prev_c);
                chk(bus.rsp_neg == prev_neg, "hold_neg", bus.rsp_neg, prev_neg);
            end

            if (bus.rsp_valid != '0) begin
                if (q.size() == 0) begin
                    chk(0, "spurious_rsp", bus.rsp_valid, 0);
                end else begin
                    if (prev_rv == '0)
                        chk(cyc == q[0].cyc + 3 + LAT, "latency", cyc - q[0].cyc, 3 + LAT);
                    if (bus.rsp_ready) begin
                        exp_t e;
                        logic [NREQ-1:0] e1h;
                        e = q.pop_front();
                        e1h = '0;
                        e1h[e.idx] = 1'b1;
                        chk(bus.rsp_valid == e1h, "rsp_idx", bus.rsp_valid, e1h);
                        chk(bus.rsp_c == e.c, "rsp_c", bus.rsp_c, e.c);
                        chk(bus.rsp_neg == e.neg, "rsp_neg", bus.rsp_neg, e.neg);
                        res_c[e.idx]   = bus.rsp_c;
                        res_neg[e.idx] = bus.rsp_neg;
                        busy = 0;
                    end
                end
            end
            prev_rv   = bus.rsp_valid;
            prev_c    = bus.rsp_c;
            prev_neg  = bus.rsp_neg;
            prev_wait = (bus.rsp_valid != '0) && !bus.rsp_ready;
        end
    end

    task automatic drive();
        bus.req_valid = want;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[6*i +: 6] = opa[i];
            bus.req_b[6*i +: 6] = opb[i];
        end
    endtask

    task automatic new_ops(input int i);
        opa[i] = 6'($urandom);
        opb[i] = 6'($urandom);
    endtask

    task automatic req(input int i, input logic [5:0] a, input logic [5:0] b);
        opa[i] = a; opb[i] = b; want[i] = 1'b1;
        drive();
    endtask

    // One clock: retire accepted requests, optionally re-arm/drop/arm at random
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_cnt[i] != seen_cnt[i]) begin
                seen_cnt[i] = acc_cnt[i];
                if (rearm[i]) new_ops(i);
                else want[i] = 1'b0;
            end else if (want[i] && drop_en && $urandom_range(15) == 0) begin
                want[i] = 1'b0;
            end else if (!want[i] && arm_en && $urandom_range(3) == 0) begin
                want[i] = 1'b1;
                new_ops(i);
            end
        end
        if (arm_en) bus.rsp_ready = ($urandom_range(2) != 0);
        drive();
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            if (want == '0 && !busy) done = 1;
            else step();
        end
        if (!done) chk(want == '0 && !busy, "idle_timeout", want, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        want = '0; rearm = '0;
        drive();
        step(); step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        int base;
        bit seen;
        rst = 1'b0;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(bus.mul_rst == 1'b1, "rst_mul_rst", bus.mul_rst, 1);
        chk(bus.mul_start == 1'b0, "rst_mul_start", bus.mul_start, 0);
        chk(bus.rsp_valid == '0, "rst_rsp_valid", bus.rsp_valid, 0);
        chk(bus.req_ready == '0, "rst_req_ready", bus.req_ready, 0);
        rst = 1'b1;
        step();
        chk(bus.mul_rst == 1'b0, "idle_mul_rst", bus.mul_rst, 0);
        repeat (4) step();
        chk(bus.rsp_valid == '0, "idle_rsp_valid", bus.rsp_valid, 0);
        chk(bus.rsp_c == '0, "idle_rsp_c", bus.rsp_c, 0);
        chk(bus.rsp_neg == 1'b0, "idle_rsp_neg", bus.rsp_neg, 0);
        chk(bus.mul_a == '0, "idle_mul_a", bus.mul_a, 0);
        chk(bus.mul_b == '0, "idle_mul_b", bus.mul_b, 0);
        chk(bus.mul_start == 1'b0, "idle_mul_start", bus.mul_start, 0);

        // Single operation: 9 * -7
        req(0, 6'd9, 6'b111001);
        wait_idle(40);
        chk(res_c[0] == 12'd63, "op0_c", res_c[0], 63);
        chk(res_neg[0] == 1'b1, "op0_neg", res_neg[0], 1);

        // All four at once right after reset: grants 0,1,2,3
        do_reset();
        base = glog.size();
        for (int i = 0; i < NREQ; i++) new_ops(i);
        opa[2] = 6'd20; opb[2] = 6'd5;
        want = '1;
        drive();
        wait_idle(100);
        chk(glog.size() == base + 4, "all4_count", glog.size() - base, 4);
        for (int k = 0; k < 4 && base + k < glog.size(); k++)
            chk(glog[base + k] == k, "all4_order", glog[base + k], k);
        chk(res_c[2] == 12'd100, "op2_c", res_c[2], 100);
        chk(res_neg[2] == 1'b0, "op2_neg", res_neg[2], 0);

        // Requesters 1 and 3 held continuously must alternate
        base = glog.size();
        rearm = 4'b1010;
        req(1, 6'($urandom), 6'($urandom));
        req(3, 6'($urandom), 6'($urandom));
        for (int n = 0; n < 200 && glog.size() < base + 6; n++) step();
        rearm = '0;
        wait_idle(60);
        chk(glog.size() >= base + 6, "alt_count", glog.size() - base, 6);
        for (int k = base + 1; k < glog.size(); k++) begin
            chk(glog[k] != glog[k-1], "alt_no_repeat", glog[k], 4 - glog[k-1]);
            chk(glog[k] == 1 || glog[k] == 3, "alt_member", glog[k], 1);
        end

        // Stall the response for 20 cycles while another requester waits
        bus.rsp_ready = 1'b0;
        base = glog.size();
        req(0, 6'($urandom), 6'($urandom));
        seen = 0;
        for (int n = 0; n < 30 && !seen; n++) begin
            step();
            if (bus.rsp_valid != '0) seen = 1;
        end
        chk(seen, "stall_rsp_seen", seen, 1);
        req(2, 6'($urandom), 6'($urandom));
        repeat (20) step();
        chk(bus.rsp_valid == 4'b0001, "stall_valid", bus.rsp_valid, 1);
        chk(glog.size() == base + 1, "stall_no_grant", glog.size() - base, 1);
        bus.rsp_ready = 1'b1;
        wait_idle(60);

        // Reset while the multiplier is running
        req(2, 6'($urandom), 6'($urandom));
        seen = 0;
        for (int n = 0; n < 30 && !seen; n++) begin
            step();
            if (bus.mul_start) seen = 1;
        end
        chk(seen, "run_seen", seen, 1);
        step();
        #3;
        rst = 1'b0;
        want = '0;
        drive();
        #1;
        chk(bus.mul_rst == 1'b1, "midrst_mul_rst", bus.mul_rst, 1);
        chk(bus.mul_start == 1'b0, "midrst_mul_start", bus.mul_start, 0);
        chk(bus.rsp_valid == '0, "midrst_rsp_valid", bus.rsp_valid, 0);
        chk(bus.mul_a == '0, "midrst_mul_a", bus.mul_a, 0);
        step(); step();
        rst = 1'b1;
        repeat (LAT + 6) step();
        chk(bus.rsp_valid == '0, "midrst_no_rsp", bus.rsp_valid, 0);
        base = glog.size();
        req(3, 6'($urandom), 6'($urandom));
        req(0, 6'($urandom), 6'($urandom));
        wait_idle(60);
        chk(glog.size() == base + 2, "post_rst_count", glog.size() - base, 2);
        if (glog.size() == base + 2) begin
            chk(glog[base] == 0, "post_rst_first", glog[base], 0);
            chk(glog[base + 1] == 3, "post_rst_second", glog[base + 1], 3);
        end

        // Random traffic with random back-pressure and dropped requests
        arm_en = 1; drop_en = 1;
        repeat (600) step();
        arm_en = 0; drop_en = 0;
        bus.rsp_ready = 1'b1;
        want = '0;
        drive();
        wait_idle(60);
        chk(q.size() == 0, "drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
